bus_sequencer: RTL

//  Hardwired control-step FSM for the 32-bit CPU datapath.

---
 rtl/cpu_ctrl_pkg.sv | 38 +++
 rtl/instr_decoder.sv | 19 +
 rtl/bus_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU codes, bus source indices, states and instruction classes for bus_sequencer
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;
  typedef enum logic [3:0] {
    C_RTYPE, C_IMM, C_LD, C_LDI, C_ST, C_MULDIV, C_MOVE, C_IO, C_NOP, C_HALT, C_ILLEGAL
  } iclass_t;
  // R-type, mul and div opcodes double as their own ALU function codes
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_ANDI = 5'd10;
  localparam logic [4:0] OP_ORI  = 5'd11;
  localparam logic [4:0] OP_LD   = 5'd12;
  localparam logic [4:0] OP_LDI  = 5'd13;
  localparam logic [4:0] OP_ST   = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_MFHI = 5'd17;
  localparam logic [4:0] OP_MFLO = 5'd18;
  localparam logic [4:0] OP_IN   = 5'd19;
  localparam logic [4:0] OP_OUT  = 5'd20;
  localparam logic [4:0] OP_NOP  = 5'd21;
  localparam logic [4:0] OP_HALT = 5'd22;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] BS_HI   = 5'd16;
  localparam logic [4:0] BS_LO   = 5'd17;
  localparam logic [4:0] BS_ZHI  = 5'd18;
  localparam logic [4:0] BS_ZLO  = 5'd19;
  localparam logic [4:0] BS_PC   = 5'd20;
  localparam logic [4:0] BS_MDR  = 5'd21;
  localparam logic [4:0] BS_INP  = 5'd22;
  localparam logic [4:0] BS_C    = 5'd23;
  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_ADD;
  endfunction
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: maps a 5-bit opcode to its control-step class
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_op,
  output iclass_t    o_class
);
  always_comb
    o_class = i_op <= OP_ROL                     ? C_RTYPE  :
              i_op <= OP_ORI                     ? C_IMM    :
              i_op == OP_LD                      ? C_LD     :
              i_op == OP_LDI                     ? C_LDI    :
              i_op == OP_ST                      ? C_ST     :
              i_op == OP_MUL || i_op == OP_DIV   ? C_MULDIV :
              i_op == OP_MFHI || i_op == OP_MFLO ? C_MOVE   :
              i_op == OP_IN || i_op == OP_OUT    ? C_IO     :
              i_op == OP_NOP                     ? C_NOP    :
              i_op == OP_HALT                    ? C_HALT   : C_ILLEGAL;
endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: hardwired fetch/execute control-step FSM driving one-hot bus selects and load enables.
// Optional memory-wait timeout fault enabled by defining MEM_WAIT_TIMEOUT_EN.
module bus_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        i_clock,
  input  logic        i_clear_n,
  input  logic        i_run,
  input  logic [31:0] i_ir,
  input  logic        i_mem_ready,
  output logic [23:0] o_bus_sel,
  output logic [15:0] o_reg_in,
  output logic        o_pc_in,
  output logic        o_ir_in,
  output logic        o_mar_in,
  output logic        o_mdr_in,
  output logic        o_y_in,
  output logic        o_z_in,
  output logic        o_hi_in,
  output logic        o_lo_in,
  output logic        o_outport_in,
  output logic        o_mdr_from_mem,
  output logic        o_inc_pc,
  output logic [4:0]  o_alu_op,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_done,
  output logic        o_halted,
  output logic        o_fault
);
  state_t      r_state;
  logic        r_fault;
  iclass_t     w_class;
  logic [4:0]  w_op;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic [4:0]  w_src;
  logic        w_src_en;
  logic        w_reg_en;
  logic        w_wait;
  logic        w_tmo_hit;
  logic        w_unused;
  assign w_op = i_ir[31:27];
  assign w_ra = i_ir[26:23];
  assign w_rb = i_ir[22:19];
  assign w_rc = i_ir[18:15];
  assign w_unused = ^{i_ir[14:0], MEM_TIMEOUT > 0, TIMEOUT_W > 0};
  instr_decoder u_dec (.i_op(w_op), .o_class(w_class));
  assign w_wait = r_state == S_T1 || (r_state == S_T6 && w_class == C_LD) ||
                  (r_state == S_T7 && w_class == C_ST);
`ifdef MEM_WAIT_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo;
  logic                 w_waiting;
  assign w_waiting = w_wait && !i_mem_ready;
  assign w_tmo_hit = w_waiting && r_tmo == TIMEOUT_W'(MEM_TIMEOUT - 1);
  always_ff @(posedge i_clock)
    r_tmo <= (!i_clear_n || !w_waiting) ? '0 : r_tmo + TIMEOUT_W'(1);
`else
  assign w_tmo_hit = 1'b0;
`endif
  // done marks the instruction boundary, so it also steers the next state
  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      r_state <= S_IDLE;
      r_fault <= 1'b0;
    end else if (w_tmo_hit) begin
      r_state <= S_HALT;
      r_fault <= 1'b1;
    end else if (o_done) begin
      r_state <= (w_class == C_HALT || w_class == C_ILLEGAL) ? S_HALT : i_run ? S_T0 : S_IDLE;
      r_fault <= r_fault || w_class == C_ILLEGAL;
    end else if (r_state == S_IDLE) begin
      r_state <= i_run ? S_T0 : S_IDLE;
    end else if (r_state != S_HALT && !(w_wait && !i_mem_ready)) begin
      r_state <= state_t'(r_state + 4'd1);
    end
  end
  always_comb begin
    w_src_en       = 1'b0;
    w_src          = '0;
    w_reg_en       = 1'b0;
    o_pc_in        = 1'b0;
    o_ir_in        = 1'b0;
    o_mar_in       = 1'b0;
    o_mdr_in       = 1'b0;
    o_y_in         = 1'b0;
    o_z_in         = 1'b0;
    o_hi_in        = 1'b0;
    o_lo_in        = 1'b0;
    o_outport_in   = 1'b0;
    o_mdr_from_mem = 1'b0;
    o_inc_pc       = 1'b0;
    o_alu_op       = ALU_ADD;
    o_mem_read     = 1'b0;
    o_mem_write    = 1'b0;
    o_done         = 1'b0;
    case (r_state)
      S_T0: begin
        w_src_en = 1'b1;
        w_src    = BS_PC;
        o_mar_in = 1'b1;
        o_inc_pc = 1'b1;
        o_z_in   = 1'b1;
      end
      S_T1: begin
        w_src_en       = 1'b1;
        w_src          = BS_ZLO;
        o_pc_in        = 1'b1;
        o_mem_read     = 1'b1;
        o_mdr_in       = 1'b1;
        o_mdr_from_mem = 1'b1;
      end
      S_T2: begin
        w_src_en = 1'b1;
        w_src    = BS_MDR;
        o_ir_in  = 1'b1;
      end
      S_T3: case (w_class)
        C_MULDIV: begin
          w_src_en = 1'b1;
          w_src    = {1'b0, w_ra};
          o_y_in   = 1'b1;
        end
        C_MOVE: begin
          w_src_en = 1'b1;
          w_src    = w_op == OP_MFHI ? BS_HI : BS_LO;
          w_reg_en = 1'b1;
          o_done   = 1'b1;
        end
        C_IO: begin
          w_src_en     = 1'b1;
          w_src        = w_op == OP_IN ? BS_INP : {1'b0, w_ra};
          w_reg_en     = w_op == OP_IN;
          o_outport_in = w_op != OP_IN;
          o_done       = 1'b1;
        end
        C_NOP, C_HALT, C_ILLEGAL: o_done = 1'b1;
        default: begin
          w_src_en = 1'b1;
          w_src    = {1'b0, w_rb};
          o_y_in   = 1'b1;
        end
      endcase
      S_T4: begin
        w_src_en = 1'b1;
        o_z_in   = 1'b1;
        w_src    = w_class == C_RTYPE ? {1'b0, w_rc} : w_class == C_MULDIV ? {1'b0, w_rb} : BS_C;
        o_alu_op = (w_class == C_RTYPE || w_class == C_MULDIV) ? w_op :
                   w_class == C_IMM ? imm_alu(w_op) : ALU_ADD;
      end
      S_T5: begin
        w_src_en = 1'b1;
        w_src    = BS_ZLO;
        o_mar_in = w_class == C_LD || w_class == C_ST;
        o_lo_in  = w_class == C_MULDIV;
        w_reg_en = w_class == C_RTYPE || w_class == C_IMM || w_class == C_LDI;
        o_done   = w_class == C_RTYPE || w_class == C_IMM || w_class == C_LDI;
      end
      S_T6: case (w_class)
        C_LD: begin
          o_mem_read     = 1'b1;
          o_mdr_in       = 1'b1;
          o_mdr_from_mem = 1'b1;
        end
        C_ST: begin
          w_src_en = 1'b1;
          w_src    = {1'b0, w_ra};
          o_mdr_in = 1'b1;
        end
        C_MULDIV: begin
          w_src_en = 1'b1;
          w_src    = BS_ZHI;
          o_hi_in  = 1'b1;
          o_done   = 1'b1;
        end
        default: ;
      endcase
      S_T7: case (w_class)
        C_LD: begin
          w_src_en = 1'b1;
          w_src    = BS_MDR;
          w_reg_en = 1'b1;
          o_done   = 1'b1;
        end
        C_ST: begin
          o_mem_write = 1'b1;
          o_done      = i_mem_ready;
        end
        default: ;
      endcase
      default: ;
    endcase
  end
  // a single encoded source/destination makes multiple drivers impossible
  assign o_bus_sel = w_src_en ? 24'(1) << w_src : '0;
  assign o_reg_in  = w_reg_en ? 16'(1) << w_ra : '0;
  assign o_halted  = r_state == S_HALT;
  assign o_fault   = r_fault;
endmodule
